// File: rtl/cgra_sram_pkg.sv
// Shared types for the banked CGRA SRAM wrapper.
// Holds the retention FSM state enum and the bank-index width helper.
package cgra_sram_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    RET,
    WAKE
  } ret_state_e;

  function automatic int unsigned bank_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cgra_sram_ret_fsm.sv
// Retention sequencer: ACTIVE/DRAIN/RET/WAKE with wake-up counter.
// Ports: clk, rst_n, set_ret in; gnt_en, ret_ack, bank_ret out.
module cgra_sram_ret_fsm
  import cgra_sram_pkg::*;
#(
  parameter int unsigned NumBanks      = 4,
  parameter int unsigned RetWakeCycles = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_ret,
  output logic                gnt_en,
  output logic                ret_ack,
  output logic [NumBanks-1:0] bank_ret
);

  localparam int unsigned CntW =
    (RetWakeCycles > 1) ? $clog2(RetWakeCycles) : 1;

  ret_state_e      state;
  ret_state_e      state_n;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ACTIVE: begin
        if (set_ret) state_n = DRAIN;
      end
      DRAIN: begin
        state_n = RET;
      end
      RET: begin
        if (!set_ret) begin
          state_n = WAKE;
          cnt_n   = CntW'(RetWakeCycles - 1);
        end
      end
      WAKE: begin
        // a renewed request overrides the wake-up in progress
        if (set_ret) begin
          state_n = RET;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = ACTIVE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = ACTIVE;
    endcase
  end

  // retention outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ACTIVE;
      cnt      <= '0;
      ret_ack  <= 1'b0;
      bank_ret <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ret_ack  <= (state_n == RET);
      bank_ret <= {NumBanks{state_n == RET}};
    end
  end

  assign gnt_en = rst_n && (state == ACTIVE);

endmodule

// File: rtl/tc_sram.sv
// Behavioural single-cycle SRAM macro with byte enables.
// Ports: clk_i, rst_ni, per-port req/we/addr/wdata/be in, rdata out.
module tc_sram #(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 1,
  localparam int unsigned AddrWidth =
    (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth = DataWidth / ByteWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumPorts-1:0]                  req_i,
  input  logic [NumPorts-1:0]                  we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]     be_i,
  output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o
);

  logic [DataWidth-1:0] mem [NumWords];

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (req_i[p] && we_i[p]) begin
        for (int i = 0; i < BeWidth; i++) begin
          if (be_i[p][i]) begin
            mem[addr_i[p]][i*ByteWidth +: ByteWidth] <=
              wdata_i[p][i*ByteWidth +: ByteWidth];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (req_i[p] && !we_i[p]) rdata_o[p] <= mem[addr_i[p]];
      end
    end
  end

endmodule

// File: rtl/cgra_sram_banked_wrapper.sv
// Multi-bank SRAM wrapper: bank decode, read mux, range check, retention.
// Ports: req/gnt, we, addr, wdata, be, rvalid, rdata, err, retention.
module cgra_sram_banked_wrapper
  import cgra_sram_pkg::*;
#(
  parameter int unsigned NumBanks      = 4,
  parameter int unsigned WordsPerBank  = 256,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned RetWakeCycles = 4,
  parameter int unsigned BankBits      = bank_bits(NumBanks),
  parameter int unsigned WordBits      = $clog2(WordsPerBank),
  parameter int unsigned AddrWidth     = BankBits + WordBits
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   we_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] be_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o,
  input  logic                   set_retentive_i,
  output logic                   ret_ack_o,
  output logic [NumBanks-1:0]    bank_ret_o
);

  logic                               gnt_en;
  logic [BankBits-1:0]                bank;
  logic [WordBits-1:0]                row;
  logic [31:0]                        bank_ext;
  logic                               oor;
  logic [NumBanks-1:0]                bank_req;
  logic [NumBanks-1:0][DataWidth-1:0] bank_rdata;
  logic                               rvalid_q;
  logic                               err_q;
  logic [BankBits-1:0]                bank_q;

  cgra_sram_ret_fsm #(
    .NumBanks      (NumBanks),
    .RetWakeCycles (RetWakeCycles)
  ) u_ret_fsm (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .set_ret  (set_retentive_i),
    .gnt_en   (gnt_en),
    .ret_ack  (ret_ack_o),
    .bank_ret (bank_ret_o)
  );

  assign gnt_o    = req_i & gnt_en;
  assign bank     = addr_i[AddrWidth-1 -: BankBits];
  assign row      = addr_i[WordBits-1:0];
  assign bank_ext = 32'(bank);
  // only reachable when NumBanks is not a power of two
  assign oor      = (bank_ext >= NumBanks);

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    assign bank_req[b] = gnt_o & ~oor & (bank == BankBits'(b));

    tc_sram #(
      .NumWords  (WordsPerBank),
      .DataWidth (DataWidth),
      .ByteWidth (8),
      .NumPorts  (1)
    ) u_sram (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   (bank_req[b]),
      .we_i    (we_i),
      .addr_i  (row),
      .wdata_i (wdata_i),
      .be_i    (be_i),
      .rdata_o (bank_rdata[b])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      bank_q   <= '0;
    end else begin
      rvalid_q <= gnt_o & ~we_i;
      err_q    <= gnt_o & oor;
      bank_q   <= bank;
    end
  end

  // errored or idle responses read as zero
  always_comb begin
    rdata_o = '0;
    if (rvalid_q && !err_q) begin
      for (int b = 0; b < NumBanks; b++) begin
        if (bank_q == BankBits'(b)) rdata_o = bank_rdata[b];
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_cgra_sram_banked_wrapper.sv
// Scoreboard bench for the banked SRAM wrapper (NumBanks=3).
// Random traffic plus directed retention, boundary and reset cases.
module tb_cgra_sram_banked_wrapper;

  localparam int NB   = 3;
  localparam int WPB  = 256;
  localparam int AW   = 10;
  localparam int MEMW = NB * WPB;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_i = 1'b0;
  logic          gnt_o;
  logic          we_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [31:0]   wdata_i = '0;
  logic [3:0]    be_i = '0;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic          set_retentive_i = 1'b0;
  logic          ret_ack_o;
  logic [NB-1:0] bank_ret_o;

  cgra_sram_banked_wrapper #(
    .NumBanks      (NB),
    .WordsPerBank  (WPB),
    .DataWidth     (32),
    .RetWakeCycles (4)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_i           (req_i),
    .gnt_o           (gnt_o),
    .we_i            (we_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .be_i            (be_i),
    .rvalid_o        (rvalid_o),
    .rdata_o         (rdata_o),
    .err_o           (err_o),
    .set_retentive_i (set_retentive_i),
    .ret_ack_o       (ret_ack_o),
    .bank_ret_o      (bank_ret_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          is_rd;
    bit          err;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem[1024];
  bit          known[1024];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
  endfunction

  // monitor: pops the expected response due in this cycle
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("rvalid", 32'(rvalid_o), 32'(e.is_rd));
        check("err", 32'(err_o), 32'(e.err));
        if (e.is_rd && e.chk) check("rdata", rdata_o, e.data);
      end else begin
        check("idle", {30'd0, rvalid_o, err_o}, 32'd0);
      end
    end
  end

  task automatic drive(input bit req, input bit we,
                       input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit sret,
                       input bit rstn, input bit exp_gnt,
                       input string tag);
    exp_t e;
    int   ai;
    @(negedge clk);
    req_i = req; we_i = we; addr_i = a; wdata_i = wd; be_i = be;
    set_retentive_i = sret; rst_ni = rstn;
    #1;
    check({tag, " gnt"}, 32'(gnt_o), 32'(exp_gnt));
    if (!rstn) begin
      sb.delete();
      foreach (known[i]) known[i] = 1'b0;
    end
    if (exp_gnt) begin
      ai = int'(a);
      e.due = cyc + 1;
      e.data = '0;
      if (we) begin
        if (ai < MEMW) begin
          for (int k = 0; k < 4; k++)
            if (be[k]) mem[ai][8*k +: 8] = wd[8*k +: 8];
          if (be == 4'hF) known[ai] = 1'b1;
        end else begin
          e.is_rd = 1'b0; e.err = 1'b1; e.chk = 1'b0;
          sb.push_back(e);
        end
      end else begin
        e.is_rd = 1'b1;
        e.err   = (ai >= MEMW);
        e.chk   = (ai >= MEMW) || known[ai];
        e.data  = (ai >= MEMW) ? 32'd0 : mem[ai];
        sb.push_back(e);
      end
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    drive(1, 1, a, d, be, 0, 1, 1, "wr");
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1, 0, a, 0, 0, 0, 1, 1, "rd");
  endtask

  task automatic ret_drive(input bit req, input bit sret,
                           input bit rstn, input bit exp_gnt,
                           input bit exp_ack, input string tag);
    drive(req, 0, 10'h100, 0, 0, sret, rstn, exp_gnt, tag);
    check({tag, " ret_ack"}, 32'(ret_ack_o), 32'(exp_ack));
    check({tag, " bank_ret"}, 32'(bank_ret_o),
          exp_ack ? 32'h7 : 32'h0);
  endtask

  initial begin
    logic [AW-1:0] a;
    bit            rq;
    bit            w;

    repeat (3) drive(1, 0, 10'h005, 0, 0, 0, 0, 0, "rst");
    check("rst rvalid", 32'(rvalid_o), 0);
    check("rst err", 32'(err_o), 0);
    check("rst rdata", rdata_o, 0);
    check("rst ret_ack", 32'(ret_ack_o), 0);
    check("rst bank_ret", 32'(bank_ret_o), 0);
    mon_en = 1'b1;

    wr(10'h005, 32'hDEADBEEF, 4'hF);
    wr(10'h205, 32'hDEADBEEF, 4'hF);
    wr(10'h205, 32'hA5A5A5A5, 4'h3);
    rd(10'h005);
    rd(10'h205);
    drive(0, 0, 0, 0, 0, 0, 1, 0, "idle");
    check("merge model", mem[10'h205], 32'hDEADA5A5);

    wr(10'h0FF, 32'h11110FF0, 4'hF);
    wr(10'h100, 32'h22221000, 4'hF);
    wr(10'h1FF, 32'h33331FF0, 4'hF);
    wr(10'h200, 32'h44442000, 4'hF);
    rd(10'h0FF); rd(10'h100); rd(10'h1FF); rd(10'h200);

    wr(10'h0AB, 32'hB0B0B0B0, 4'hF);
    wr(10'h1AB, 32'hB1B1B1B1, 4'hF);
    wr(10'h2AB, 32'hB2B2B2B2, 4'hF);
    wr(10'h3AB, 32'hFFFFFFFF, 4'hF);
    rd(10'h3AB);
    rd(10'h0AB); rd(10'h1AB); rd(10'h2AB);

    for (int i = 0; i < 300; i++) begin
      rq = ($urandom_range(3) != 0);
      w  = $urandom_range(1);
      a  = AW'($urandom_range(1023));
      drive(rq, w, a, $urandom, 4'($urandom_range(15)),
            0, 1, rq, "rand");
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, "idle");

    ret_drive(1, 1, 1, 1, 0, "ret rise");
    ret_drive(1, 1, 1, 0, 0, "drain");
    ret_drive(1, 1, 1, 0, 1, "ret");
    ret_drive(1, 0, 1, 0, 1, "ret fall");
    for (int i = 0; i < 4; i++) ret_drive(1, 0, 1, 0, 0, "wake");
    ret_drive(1, 0, 1, 1, 0, "first gnt");

    ret_drive(0, 1, 1, 0, 0, "ret2 rise");
    ret_drive(1, 1, 1, 0, 0, "drain2");
    ret_drive(1, 1, 1, 0, 1, "ret2");
    ret_drive(1, 0, 1, 0, 1, "ret2 fall");
    ret_drive(1, 0, 1, 0, 0, "wake2");
    ret_drive(1, 1, 1, 0, 0, "wake2 rearm");
    ret_drive(1, 1, 1, 0, 1, "ret again");
    ret_drive(1, 0, 1, 0, 1, "ret3 fall");
    ret_drive(1, 0, 1, 0, 0, "wake3");
    ret_drive(1, 0, 0, 0, 0, "wake rst");
    ret_drive(1, 0, 1, 1, 0, "post rst");

    drive(1, 0, 10'h0AB, 0, 0, 0, 0, 0, "cancel");
    drive(0, 0, 0, 0, 0, 0, 1, 0, "idle");
    wr(10'h155, 32'hCAFEF00D, 4'hF);
    rd(10'h155);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 0, "idle");
    check("sb drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
